// File: rtl/psg_write_sequencer_if.sv
// Request handshake and PSG bus bundle shared by psg_write_sequencer and its driver.
interface psg_write_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_chan;
    logic             req_type;
    logic [9:0]       req_value;
    logic [7:0]       databus;
    logic             we_l;
    logic             busy;
    logic [CNT_W-1:0] count;

    modport master (
        output req_valid, req_chan, req_type, req_value,
        input  req_ready, databus, we_l, busy, count
    );

    modport slave (
        input  req_valid, req_chan, req_type, req_value,
        output req_ready, databus, we_l, busy, count
    );
endinterface

// File: rtl/psg_write_sequencer.sv
// Buffers (chan, type, value) register updates and serialises them into SN76489 latch/data
// bytes with timed we_l strobes. Define PSG_COALESCE_EN to merge updates to a queued {chan,type}.
module psg_write_sequencer #(
    parameter int DEPTH      = 4,
    parameter int WE_CYCLES  = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    psg_write_sequencer_if.slave  bus
);
    // state    | meaning
    // IDLE     | waiting for a queued request
    // POP      | head moves into the holding register
    // LATCH_LO | latch byte on databus, we_l low
    // LATCH_HI | latch byte held, we_l high
    // DATA_LO  | data byte on databus, we_l low
    // DATA_HI  | data byte held, we_l high

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TMR_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] WE_LOAD  = TMR_W'(WE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, POP, LATCH_LO, LATCH_HI, DATA_LO, DATA_HI
    } state_t;

    state_t           state_q, state_nx;
    logic [1:0]       fifo_chan  [DEPTH];
    logic             fifo_type  [DEPTH];
    logic [9:0]       fifo_value [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [TMR_W-1:0] timer_q, timer_nx;
    logic             we_l_q, we_l_nx;
    logic [7:0]       databus_q, databus_nx;
    logic             hold_need_q;
    logic [5:0]       hold_data_q;
    logic [7:0]       latch_byte;
    logic             head_need;
    logic             pop, push, enqueue, match, ready;

    assign pop     = (state_q == POP);
    assign ready   = (count_q < CNT_W'(DEPTH)) || match;
    assign push    = bus.req_valid && ready;
    assign enqueue = push && !match;

    assign latch_byte = {1'b1, fifo_chan[rd_ptr_q], fifo_type[rd_ptr_q], fifo_value[rd_ptr_q][3:0]};
    assign head_need  = !fifo_type[rd_ptr_q] && (fifo_chan[rd_ptr_q] != 2'd3);

`ifdef PSG_COALESCE_EN
    logic [PTR_W-1:0] match_idx;
    logic [PTR_W-1:0] slot_ofs;

    // Only live entries count, and the head leaving this cycle is no longer a merge target.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        slot_ofs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_ofs = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(slot_ofs) < count_q) && !(pop && (slot_ofs == '0)) &&
                (fifo_chan[i] == bus.req_chan) && (fifo_type[i] == bus.req_type)) begin
                match     = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end
`else
    assign match = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (enqueue) begin
            fifo_chan[wr_ptr_q]  <= bus.req_chan;
            fifo_type[wr_ptr_q]  <= bus.req_type;
            fifo_value[wr_ptr_q] <= bus.req_value;
        end
`ifdef PSG_COALESCE_EN
        if (push && match) begin
            fifo_value[match_idx] <= bus.req_value;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enqueue) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({enqueue, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            we_l_q      <= 1'b1;
            databus_q   <= 8'h00;
            hold_need_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q   <= state_nx;
            timer_q   <= timer_nx;
            we_l_q    <= we_l_nx;
            databus_q <= databus_nx;
            if (pop) begin
                hold_need_q <= head_need;
                hold_data_q <= fifo_value[rd_ptr_q][9:4];
            end
        end
    end

    // Outputs are loaded on the transition into a state so they are stable for its whole duration.
    always_comb begin
        state_nx   = state_q;
        timer_nx   = timer_q;
        we_l_nx    = we_l_q;
        databus_nx = databus_q;
        if (timer_q != '0) timer_nx = timer_q - TMR_W'(1);
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_nx = POP;
            end
            POP: begin
                state_nx   = LATCH_LO;
                timer_nx   = WE_LOAD;
                we_l_nx    = 1'b0;
                databus_nx = latch_byte;
            end
            LATCH_LO: begin
                if (timer_q == '0) begin
                    state_nx = LATCH_HI;
                    timer_nx = GAP_LOAD;
                    we_l_nx  = 1'b1;
                end
            end
            LATCH_HI: begin
                if (timer_q == '0) begin
                    if (hold_need_q) begin
                        state_nx   = DATA_LO;
                        timer_nx   = WE_LOAD;
                        we_l_nx    = 1'b0;
                        databus_nx = {2'b00, hold_data_q};
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA_LO: begin
                if (timer_q == '0) begin
                    state_nx = DATA_HI;
                    timer_nx = GAP_LOAD;
                    we_l_nx  = 1'b1;
                end
            end
            DATA_HI: begin
                if (timer_q == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.databus   = databus_q;
    assign bus.we_l      = we_l_q;
    assign bus.busy      = (count_q != '0) || (state_q != IDLE);
    assign bus.count     = count_q;
endmodule
